// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out BCD change one coin at a time via 5-unit and 1-unit hoppers
module change_dispenser #(
  parameter int PULSE_CYCLES   = 50000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       clr_n,
  input  logic       start,
  input  logic [3:0] change_sw,
  input  logic [3:0] change_gw,
  input  logic       coin5_sense,
  input  logic       coin1_sense,
  output logic       coin5_req,
  output logic       coin1_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       fault,
  output logic [6:0] remaining,
  output logic [4:0] count5,
  output logic [2:0] count1
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECIDE = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Timers count down (pulse) and up (timeout); loads chosen so REQ lasts
  // exactly PULSE_CYCLES and the fault lands TIMEOUT_CYCLES after REQ starts.
  localparam logic [19:0] PULSE_LOAD = 20'(PULSE_CYCLES - 1);
  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [6:0]  rem_q, rem_d;
  logic [4:0]  cnt5_q, cnt5_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic        sel5_q, sel5_d;
  logic [19:0] pulse_q, pulse_d;
  logic [19:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  logic s5_meta_q, s5_sync_q, s5_prev_q;
  logic s1_meta_q, s1_sync_q, s1_prev_q;

  logic       ev5, ev1, coin_ev, bad_digit;
  logic [6:0] amount, new_rem;

  // Two-flop synchronizers plus a delayed copy for rising-edge detection.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      s5_meta_q <= 1'b0;
      s5_sync_q <= 1'b0;
      s5_prev_q <= 1'b0;
      s1_meta_q <= 1'b0;
      s1_sync_q <= 1'b0;
      s1_prev_q <= 1'b0;
    end else begin
      s5_meta_q <= coin5_sense;
      s5_sync_q <= s5_meta_q;
      s5_prev_q <= s5_sync_q;
      s1_meta_q <= coin1_sense;
      s1_sync_q <= s1_meta_q;
      s1_prev_q <= s1_sync_q;
    end
  end

  // Datapath and state registers.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt5_q  <= '0;
      cnt1_q  <= '0;
      sel5_q  <= 1'b0;
      pulse_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt5_q  <= cnt5_d;
      cnt1_q  <= cnt1_d;
      sel5_q  <= sel5_d;
      pulse_q <= pulse_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: validate/load on start, pick a coin, pulse, await sensor.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt5_d    = cnt5_q;
    cnt1_d    = cnt1_q;
    sel5_d    = sel5_q;
    pulse_d   = pulse_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    ev5       = s5_sync_q & ~s5_prev_q;
    ev1       = s1_sync_q & ~s1_prev_q;
    coin_ev   = sel5_q ? ev5 : ev1;
    bad_digit = (change_sw > 4'd9) || (change_gw > 4'd9);
    amount    = ({3'b000, change_sw} << 3) + ({3'b000, change_sw} << 1) + {3'b000, change_gw};
    new_rem   = sel5_q ? (rem_q - 7'd5) : (rem_q - 7'd1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_digit) begin
            err_d = 1'b1;
          end else begin
            cnt5_d = '0;
            cnt1_d = '0;
            if (amount == 7'd0) begin
              state_d = S_DONE;
            end else begin
              rem_d   = amount;
              state_d = S_DECIDE;
            end
          end
        end
      end
      S_DECIDE: begin
        sel5_d  = (rem_q >= 7'd5);
        pulse_d = PULSE_LOAD;
        tmo_d   = '0;
        state_d = S_REQ;
      end
      S_REQ, S_WAIT: begin
        // A confirmed coin wins over a timeout landing on the same edge.
        if (coin_ev) begin
          rem_d = new_rem;
          if (sel5_q) cnt5_d = cnt5_q + 5'd1;
          else        cnt1_d = cnt1_q + 3'd1;
          state_d = (new_rem == 7'd0) ? S_DONE : S_DECIDE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 20'd1;
          if (state_q == S_REQ) begin
            if (pulse_q == 20'd0) state_d = S_WAIT;
            else                  pulse_d = pulse_q - 20'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state so reset clears them immediately.
  always_comb begin
    coin5_req = (state_q == S_REQ) &&  sel5_q;
    coin1_req = (state_q == S_REQ) && !sel5_q;
    busy      = (state_q == S_DECIDE) || (state_q == S_REQ) ||
                (state_q == S_WAIT)   || (state_q == S_FAULT);
    done      = (state_q == S_DONE);
    fault     = (state_q == S_FAULT);
    error     = err_q;
    remaining = rem_q;
    count5    = cnt5_q;
    count1    = cnt1_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser with a hopper model
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] change_sw = 4'd0;
  logic [3:0] change_gw = 4'd0;
  logic       coin5_sense = 1'b0;
  logic       coin1_sense = 1'b0;
  logic       coin5_req, coin1_req, busy, done, error, fault;
  logic [6:0] remaining;
  logic [4:0] count5;
  logic [2:0] count1;

  change_dispenser #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .clr_n(clr_n), .start(start),
    .change_sw(change_sw), .change_gw(change_gw),
    .coin5_sense(coin5_sense), .coin1_sense(coin1_sense),
    .coin5_req(coin5_req), .coin1_req(coin1_req),
    .busy(busy), .done(done), .error(error), .fault(fault),
    .remaining(remaining), .count5(count5), .count1(count1)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is5;
    int rem;
  } pulse_t;
  pulse_t exp_q[$];
  pulse_t mon_e;

  int hop5_budget = 1000;
  int hop1_budget = 1000;
  int req5_rise_cyc = 0;
  int req1_rise_cyc = 0;

  // Hopper model: sense rises 6 clocks after the request rises, held 3 clocks.
  initial forever begin
    @(posedge coin5_req);
    if (hop5_budget > 0) begin
      hop5_budget--;
      repeat (6) @(posedge clock);
      #1 coin5_sense = 1'b1;
      repeat (3) @(posedge clock);
      #1 coin5_sense = 1'b0;
    end
  end

  initial forever begin
    @(posedge coin1_req);
    if (hop1_budget > 0) begin
      hop1_budget--;
      repeat (6) @(posedge clock);
      #1 coin1_sense = 1'b1;
      repeat (3) @(posedge clock);
      #1 coin1_sense = 1'b0;
    end
  end

  // Request monitor: pops the expected pulse on each rising request and checks its width.
  bit p5 = 0, p1 = 0;
  int w5 = 0, w1 = 0;
  always @(negedge clock) begin
    if (!clr_n) begin
      p5 = 0; p1 = 0; w5 = 0; w1 = 0;
    end else begin
      if (coin5_req && !p5) begin
        req5_rise_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req5_unexpected: coin5_req rose at cycle %0d, none expected", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (!mon_e.is5 || remaining !== 7'(mon_e.rem)) begin
            n_fail++;
            $display("FAIL req5_pulse: got coin5 rem=%0d, expected is5=%0d rem=%0d", remaining, mon_e.is5, mon_e.rem);
          end
        end
      end
      if (coin1_req && !p1) begin
        req1_rise_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req1_unexpected: coin1_req rose at cycle %0d, none expected", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is5 || remaining !== 7'(mon_e.rem)) begin
            n_fail++;
            $display("FAIL req1_pulse: got coin1 rem=%0d, expected is5=%0d rem=%0d", remaining, mon_e.is5, mon_e.rem);
          end
        end
      end
      if (coin5_req) w5++;
      if (coin1_req) w1++;
      if (!coin5_req && p5) begin
        n_checks++;
        if (w5 !== 4) begin n_fail++; $display("FAIL req5_width: got %0d cycles, expected 4", w5); end
        w5 = 0;
      end
      if (!coin1_req && p1) begin
        n_checks++;
        if (w1 !== 4) begin n_fail++; $display("FAIL req1_width: got %0d cycles, expected 4", w1); end
        w1 = 0;
      end
      p5 = coin5_req;
      p1 = coin1_req;
    end
  end

  task automatic push_pulse(input bit is5, input int rem);
    pulse_t e;
    e.is5 = is5;
    e.rem = rem;
    exp_q.push_back(e);
  endtask

  // Presents start for one edge (N); returns #1 after edge N.
  task automatic do_start(input logic [3:0] sw, input logic [3:0] gw);
    @(posedge clock); #1;
    start = 1'b1; change_sw = sw; change_gw = gw;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({coin5_req, coin1_req, busy, done, error, fault, remaining, count5, count1} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", {coin5_req, coin1_req, busy, done, error, fault, remaining, count5, count1});
    end
    repeat (2) @(posedge clock);
    #1 clr_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_pay_27;
    bit ok;
    push_pulse(1, 27); push_pulse(1, 22); push_pulse(1, 17); push_pulse(1, 12);
    push_pulse(1, 7);  push_pulse(0, 2);  push_pulse(0, 1);
    do_start(4'd2, 4'd7);
    n_checks++;
    if (busy !== 1'b1 || coin5_req !== 1'b0 || remaining !== 7'd27) begin
      n_fail++;
      $display("FAIL pay27_decide: busy=%b req5=%b rem=%0d, expected 1 0 27", busy, coin5_req, remaining);
    end
    @(posedge clock); #1;
    n_checks++;
    if (coin5_req !== 1'b1) begin n_fail++; $display("FAIL pay27_first_req: got %b, expected 1", coin5_req); end
    wait_done(600, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pay27_done_timeout: done not seen, expected within 600"); end
    n_checks++;
    if (count5 !== 5'd5 || count1 !== 3'd2 || remaining !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pay27_final: c5=%0d c1=%0d rem=%0d busy=%b, expected 5 2 0 0", count5, count1, remaining, busy);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || count5 !== 5'd5) begin
      n_fail++;
      $display("FAIL pay27_done_len: done=%b c5=%0d, expected 0 5", done, count5);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pay27_leftover: %0d pulses missing, expected 0", exp_q.size()); end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_zero;
    do_start(4'd0, 4'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b, expected 1 0", done, busy);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || coin5_req !== 1'b0 || coin1_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: done=%b busy=%b req=%b%b, expected 0 0 00", done, busy, coin5_req, coin1_req);
    end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_invalid;
    bit ok;
    do_start(4'hf, 4'hf);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_ff: error=%b busy=%b, expected 1 0", error, busy);
    end
    @(posedge clock); #1;
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b0 || coin5_req !== 1'b0 || coin1_req !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_after: error=%b busy=%b req=%b%b, expected 0 0 00", error, busy, coin5_req, coin1_req);
    end
    do_start(4'ha, 4'h0);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_a0: error=%b busy=%b, expected 1 0", error, busy);
    end
    repeat (3) @(posedge clock);
    push_pulse(0, 3); push_pulse(0, 2); push_pulse(0, 1);
    do_start(4'd0, 4'd3);
    wait_done(400, ok);
    n_checks++;
    if (!ok || count5 !== 5'd0 || count1 !== 3'd3 || remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL pay03: ok=%b c5=%0d c1=%0d rem=%0d, expected 1 0 3 0", ok, count5, count1, remaining);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pay03_leftover: %0d pulses missing, expected 0", exp_q.size()); end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_ignore_start;
    bit ok;
    push_pulse(1, 10); push_pulse(1, 5);
    do_start(4'd1, 4'd0);
    repeat (3) @(posedge clock); #1;
    start = 1'b1; change_sw = 4'd0; change_gw = 4'd4;
    @(posedge clock); #1;
    start = 1'b0;
    coin1_sense = 1'b1;
    repeat (3) @(posedge clock); #1;
    coin1_sense = 1'b0;
    wait_done(400, ok);
    n_checks++;
    if (!ok || count5 !== 5'd2 || count1 !== 3'd0 || remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL ignore_start: ok=%b c5=%0d c1=%0d rem=%0d, expected 1 2 0 0", ok, count5, count1, remaining);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ignore_leftover: %0d pulses missing, expected 0", exp_q.size()); end
    repeat (5) @(posedge clock);
  endtask

  task automatic test_fault;
    bit seen;
    int fault_cyc;
    seen = 0;
    fault_cyc = 0;
    hop5_budget = 1;
    hop1_budget = 0;
    push_pulse(1, 8); push_pulse(0, 3);
    do_start(4'd0, 4'd8);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (fault) begin seen = 1; fault_cyc = cyc; break; end
    end
    n_checks++;
    if (!seen || (fault_cyc - req1_rise_cyc) != 64) begin
      n_fail++;
      $display("FAIL fault_timing: seen=%b delay=%0d, expected 1 64", seen, fault_cyc - req1_rise_cyc);
    end
    n_checks++;
    if (remaining !== 7'd3 || coin1_req !== 1'b0 || busy !== 1'b1 || count5 !== 5'd1 || count1 !== 3'd0) begin
      n_fail++;
      $display("FAIL fault_state: rem=%0d req1=%b busy=%b c5=%0d c1=%0d, expected 3 0 1 1 0", remaining, coin1_req, busy, count5, count1);
    end
    do_start(4'd0, 4'd2);
    repeat (10) @(negedge clock);
    n_checks++;
    if (fault !== 1'b1 || remaining !== 7'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_held: fault=%b rem=%0d busy=%b, expected 1 3 1", fault, remaining, busy);
    end
    hop5_budget = 1000;
    hop1_budget = 1000;
    @(posedge clock); #1 clr_n = 1'b0;
    #1;
    n_checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b busy=%b rem=%0d, expected 0 0 0", fault, busy, remaining);
    end
    @(posedge clock); #1 clr_n = 1'b1;
    exp_q.delete();
    repeat (5) @(posedge clock);
  endtask

  task automatic test_reset_mid;
    bit seen, ok;
    seen = 0;
    push_pulse(1, 15);
    do_start(4'd1, 4'd5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (coin5_req) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midreset_req: coin5_req not seen, expected high"); end
    @(posedge clock); #2 clr_n = 1'b0;
    #1;
    n_checks++;
    if ({coin5_req, coin1_req, busy, done, error, fault, remaining, count5, count1} !== 22'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, expected 0", {coin5_req, coin1_req, busy, done, error, fault, remaining, count5, count1});
    end
    @(posedge clock); #1 clr_n = 1'b1;
    exp_q.delete();
    repeat (15) @(posedge clock);
    push_pulse(1, 5);
    do_start(4'd0, 4'd5);
    wait_done(200, ok);
    n_checks++;
    if (!ok || count5 !== 5'd1 || count1 !== 3'd0 || remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL midreset_pay05: ok=%b c5=%0d c1=%0d rem=%0d, expected 1 1 0 0", ok, count5, count1, remaining);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_leftover: %0d pulses missing, expected 0", exp_q.size()); end
    repeat (5) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_pay_27();
    test_zero();
    test_invalid();
    test_ignore_start();
    test_fault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out the change computed by the vending calculator. The calculator takes coins in 5- and 1-units and produces a two-digit BCD change amount. This block takes that amount on a `start` pulse and drives the 5-unit and 1-unit coin hoppers one coin at a time. It confirms each coin with a hopper sensor event and reports completion, invalid input or a hopper fault.

## Interface
Parameters:
- PULSE_CYCLES, 50000: width in clocks of each hopper request pulse; legal range 1..2^20-1.
- TIMEOUT_CYCLES, 1000000: clocks allowed from request start to sensor event; legal range 1..2^20-1.

Ports:
- clock  in  1  system clock.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to dispense `change_sw`/`change_gw`.
- change_sw  in  4  tens digit of change, BCD; 4'hf means invalid.
- change_gw  in  4  units digit of change, BCD; 4'hf means invalid.
- coin5_sense  in  1  asynchronous hopper sensor, high while a 5-unit coin drops.
- coin1_sense  in  1  asynchronous hopper sensor, high while a 1-unit coin drops.
- coin5_req  out  1  5-unit hopper release pulse.
- coin1_req  out  1  1-unit hopper release pulse.
- busy  out  1  high from accepted `start` until DONE or FAULT.
- done  out  1  one-cycle pulse when the full amount has been paid.
- error  out  1  one-cycle pulse when `start` carries a non-BCD digit.
- fault  out  1  level; hopper timeout; held until `clr_n`.
- remaining  out  7  binary amount still to pay, 0..99.
- count5  out  5  5-unit coins paid in the current or last transaction.
- count1  out  3  1-unit coins paid in the current or last transaction.

## Operation
- All outputs reset to 0. State resets to IDLE. Timers reset to 0.
- Sensor inputs:
  - Each passes through a 2-flop synchronizer.
  - A coin event is the rising edge of the synchronized signal (0->1).
- States: IDLE, DECIDE, REQ, WAIT, DONE, FAULT.
- IDLE, on `start`=1:
  - Either digit > 9: `error`=1 for one cycle, no other change.
  - Amount 10*sw+gw = 0: go to DONE.
  - Otherwise: `remaining` <= amount, `count5` <= 0, `count1` <= 0, `busy` <= 1, go to DECIDE.
- DECIDE: select 5-unit if `remaining` >= 5, else 1-unit. Load request timer and timeout timer. Go to REQ.
- REQ:
  - Selected `*_req`=1 for exactly PULSE_CYCLES cycles, then go to WAIT with `*_req`=0.
  - If the selected coin event occurs during REQ, drop `*_req` immediately and process the event.
- WAIT: wait for the selected coin event.
- Coin event, in REQ or WAIT:
  - Subtract 5 or 1 from `remaining`; increment `count5` or `count1`.
  - If the new `remaining` = 0, go to DONE; else go to DECIDE.
- Events of the non-selected denomination are ignored and do not change counts.
- Events in IDLE, DONE or FAULT are ignored.
- Timeout timer runs through REQ and WAIT. On reaching TIMEOUT_CYCLES: go to FAULT, `*_req`=0, `fault`=1, `busy`=1 held, `remaining` frozen.
- FAULT is left only via `clr_n`.
- DONE: `done`=1 for one cycle, `busy`=0, go to IDLE. `remaining` is 0; counts are held for display.
- `start` is ignored unless the state is IDLE.
- Payout order is always all 5-unit coins first, then 1-units. Resulting counts: `count5` = amount/5, `count1` = amount%5.

## Timing
- `start` at edge N: `busy`=1 at N+1 (DECIDE); `*_req` first high at N+2.
- Zero amount: `done` high during cycle N+1 only; `busy` stays 0.
- Invalid input: `error` high during cycle N+1 only.
- Sensor latency: pin rising edge to event processing is 3 clocks (2 sync + edge register).
- Coin event processed at edge M: DECIDE at M+1, next `*_req` at M+2; or `done` at M+1 if finished.
- Request pulse width is exactly PULSE_CYCLES unless cut short by the event.
- Timeout counted from the first cycle of REQ. `fault` rises TIMEOUT_CYCLES clocks later.
- `clr_n` asserted mid-transaction clears all outputs asynchronously, including `*_req`. No resume after reset.

## Test plan
Bench parameters: PULSE_CYCLES=4, TIMEOUT_CYCLES=64. Hopper model raises the matching sense 6 clocks after the request rises, held for 3 clocks.
- start with sw=2, gw=7 -> five `coin5_req` pulses then two `coin1_req` pulses; `remaining` steps 27,22,...,2,1,0; `done` one cycle; `count5`=5, `count1`=2.
- start with sw=0, gw=0 -> `done` on the cycle after start; no req pulses; `busy` stays 0.
- start with sw=f, gw=f -> one-cycle `error`, no req, `busy`=0; a following start with 0,3 pays three 1-unit coins.
- start with 0,8, model stops after the first coin -> `fault`=1 exactly 64 clocks after the second REQ begins; `remaining`=3; `coin1_req`=0; later start ignored.
- start with 1,0, then start with 0,4 during busy, plus a spurious `coin1_sense` pulse -> second start ignored; `count1`=0; two coin5; `done`.
- `clr_n` pulsed while `coin5_req` is high -> all outputs 0 immediately; a new start with 0,5 completes normally.
